// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shift unit: operation modes and controller states.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROL = 2'b11
    } shift_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } shift_state_t;

    // Width needed to hold a per-cycle shift amount in the range 0..step.
    function automatic int step_amount_width(input int step);
        return $clog2(step + 1);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift stage: moves value by k (0..STEP) positions in the given mode.
module shift_step
    import shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 1,
    localparam int KW    = step_amount_width(STEP)
) (
    input  logic [WIDTH-1:0] value,
    input  logic [KW-1:0]    k,
    input  shift_mode_t      mode,
    input  logic             sign,
    output logic [WIDTH-1:0] result
);

    logic [2*WIDTH-1:0] ext_sra;
    logic [2*WIDTH-1:0] ext_rol;

    always_comb begin
        result  = value;
        // Arithmetic fill comes from the latched sign, not the current MSB.
        ext_sra = {{WIDTH{sign}}, value} >> k;
        ext_rol = {value, value} << k;
        case (mode)
            SH_SLL:  result = value << k;
            SH_SRL:  result = value >> k;
            SH_SRA:  result = ext_sra[WIDTH-1:0];
            SH_ROL:  result = ext_rol[2*WIDTH-1:WIDTH];
            default: result = value;
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift unit: loads an operand on start, shifts up to STEP bits per clock,
// then pulses done for one cycle with the result held on C.
//
//   state    | meaning
//   ST_IDLE  | waiting for start; C holds the last result
//   ST_SHIFT | applying min(cnt, STEP) positions per clock
//   ST_DONE  | result valid on C, done pulsed; start still ignored
module shift_unit_seq
    import shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 1,
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [SW-1:0]    SHAMT,
    input  logic [1:0]       MODE,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] C
);

    localparam int             KW     = step_amount_width(STEP);
    localparam logic [SW:0]    STEP_W = (SW + 1)'(STEP);
    localparam logic [KW-1:0]  STEP_K = KW'(STEP);

    shift_state_t      state;
    shift_state_t      state_next;
    logic [SW-1:0]     cnt;
    logic [SW-1:0]     cnt_next;
    shift_mode_t       mode_q;
    shift_mode_t       mode_next;
    logic              sign_q;
    logic              sign_next;
    logic [WIDTH-1:0]  c_next;
    logic [KW-1:0]     k;
    logic [WIDTH-1:0]  stepped;

    always_comb begin
        k = STEP_K;
        if ({1'b0, cnt} < STEP_W) begin
            k = KW'(cnt);
        end
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .value  (C),
        .k      (k),
        .mode   (mode_q),
        .sign   (sign_q),
        .result (stepped)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            C      <= '0;
            cnt    <= '0;
            mode_q <= SH_SLL;
            sign_q <= 1'b0;
        end else begin
            state  <= state_next;
            C      <= c_next;
            cnt    <= cnt_next;
            mode_q <= mode_next;
            sign_q <= sign_next;
        end
    end

    always_comb begin
        state_next = state;
        c_next     = C;
        cnt_next   = cnt;
        mode_next  = mode_q;
        sign_next  = sign_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    c_next     = A;
                    cnt_next   = SHAMT;
                    mode_next  = shift_mode_t'(MODE);
                    sign_next  = A[WIDTH-1];
                    state_next = (SHAMT != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                c_next   = stepped;
                cnt_next = cnt - SW'(k);
                if (cnt == SW'(k)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq: three configurations (8/1, 8/2, 32/32) checked
// against a bit-by-bit reference model and directed latency/handshake scenarios.
module tb_shift_unit_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        st1, st2, st3;
    logic [7:0]  a1, a2;
    logic [31:0] a3;
    logic [2:0]  sh1, sh2;
    logic [4:0]  sh3;
    logic [1:0]  md1, md2, md3;
    logic        busy1, busy2, busy3;
    logic        done1, done2, done3;
    logic [7:0]  c1, c2;
    logic [31:0] c3;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    shift_unit_seq #(.WIDTH(8), .STEP(1)) u_w8s1 (
        .clk(clk), .rst(rst), .start(st1), .A(a1), .SHAMT(sh1), .MODE(md1),
        .busy(busy1), .done(done1), .C(c1)
    );

    shift_unit_seq #(.WIDTH(8), .STEP(2)) u_w8s2 (
        .clk(clk), .rst(rst), .start(st2), .A(a2), .SHAMT(sh2), .MODE(md2),
        .busy(busy2), .done(done2), .C(c2)
    );

    shift_unit_seq #(.WIDTH(32), .STEP(32)) u_w32s32 (
        .clk(clk), .rst(rst), .start(st3), .A(a3), .SHAMT(sh3), .MODE(md3),
        .busy(busy3), .done(done3), .C(c3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int which, input logic s, input logic [31:0] a,
                         input int sh, input int md);
        case (which)
            1: begin st1 = s; a1 = a[7:0]; sh1 = 3'(sh); md1 = 2'(md); end
            2: begin st2 = s; a2 = a[7:0]; sh2 = 3'(sh); md2 = 2'(md); end
            default: begin st3 = s; a3 = a; sh3 = 5'(sh); md3 = 2'(md); end
        endcase
    endtask

    function automatic logic get_done(input int which);
        case (which)
            1: return done1;
            2: return done2;
            default: return done3;
        endcase
    endfunction

    function automatic logic get_busy(input int which);
        case (which)
            1: return busy1;
            2: return busy2;
            default: return busy3;
        endcase
    endfunction

    function automatic logic [31:0] get_c(input int which);
        case (which)
            1: return {24'h0, c1};
            2: return {24'h0, c2};
            default: return c3;
        endcase
    endfunction

    // Reference: each result bit is picked from its source position by the mode rule.
    function automatic logic [31:0] ref_shift(input int w, input logic [31:0] a,
                                              input int sh, input int md);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (md)
                0: r[5'(i)] = (i >= sh) ? a[5'(i - sh)] : 1'b0;
                1: r[5'(i)] = (i + sh < w) ? a[5'(i + sh)] : 1'b0;
                2: r[5'(i)] = (i + sh < w) ? a[5'(i + sh)] : a[5'(w - 1)];
                default: r[5'(i)] = a[5'((i - sh + w) % w)];
            endcase
        end
        return r;
    endfunction

    // Issues one op from IDLE, throws junk at the inputs while busy, returns the done cycle.
    task automatic run_op(input int which, input logic [31:0] a, input int sh, input int md,
                          output int lat, output logic [31:0] res);
        lat = -1;
        res = '0;
        drive(which, 1'b1, a, sh, md);
        tick();
        drive(which, 1'b0, a, sh, md);
        for (int cyc = 1; cyc <= 100; cyc++) begin
            if (get_done(which)) begin
                lat = cyc;
                res = get_c(which);
                break;
            end
            drive(which, 1'($urandom_range(1, 0)), $urandom(), int'($urandom_range(31, 0)),
                  int'($urandom_range(3, 0)));
            tick();
        end
        drive(which, 1'b0, a, sh, md);
        if (lat < 0) begin
            compared++;
            mismatched++;
            $display("FAIL run_op_timeout: inst %0d no done within 100 cycles (required done)", which);
        end else begin
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int w = 1; w <= 3; w++) drive(w, 1'b0, '0, 0, 0);
        tick();
        tick();
        for (int w = 1; w <= 3; w++) begin
            compared++;
            if (get_busy(w) !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_busy inst %0d: got %b expected 0", w, get_busy(w));
            end
            compared++;
            if (get_done(w) !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_done inst %0d: got %b expected 0", w, get_done(w));
            end
            compared++;
            if (get_c(w) !== 32'h0) begin
                mismatched++;
                $display("FAIL reset_c inst %0d: got %h expected 0", w, get_c(w));
            end
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_sll_busy_window();
        drive(1, 1'b1, 32'h03, 3, 0);
        tick();
        drive(1, 1'b0, 32'h03, 3, 0);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            compared++;
            if (busy1 !== (cyc <= 4)) begin
                mismatched++;
                $display("FAIL sll_busy cycle %0d: got %b expected %b", cyc, busy1, (cyc <= 4));
            end
            compared++;
            if (done1 !== (cyc == 4)) begin
                mismatched++;
                $display("FAIL sll_done cycle %0d: got %b expected %b", cyc, done1, (cyc == 4));
            end
            if (cyc >= 4) begin
                compared++;
                if (c1 !== 8'h18) begin
                    mismatched++;
                    $display("FAIL sll_result cycle %0d: got %h expected 18", cyc, c1);
                end
            end
            if (cyc == 2) drive(1, 1'b1, 32'hFF, 1, 3);
            else          drive(1, 1'b0, 32'hFF, 1, 3);
            tick();
        end
    endtask

    task automatic test_sra_srl();
        int          lat;
        logic [31:0] res;
        run_op(1, 32'h80, 2, 2, lat, res);
        compared++;
        if (lat !== 3) begin
            mismatched++;
            $display("FAIL sra_latency: got %0d expected 3", lat);
        end
        compared++;
        if (res !== 32'hE0) begin
            mismatched++;
            $display("FAIL sra_result: got %h expected e0", res);
        end
        run_op(1, 32'h80, 2, 1, lat, res);
        compared++;
        if (res !== 32'h20) begin
            mismatched++;
            $display("FAIL srl_result: got %h expected 20", res);
        end
    endtask

    task automatic test_rol_step2();
        int          lat;
        logic [31:0] res;
        run_op(2, 32'h96, 5, 3, lat, res);
        compared++;
        if (lat !== 4) begin
            mismatched++;
            $display("FAIL rol_latency: got %0d expected 4", lat);
        end
        compared++;
        if (res !== 32'hD2) begin
            mismatched++;
            $display("FAIL rol_result: got %h expected d2", res);
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 1'b1, 32'hA5, 0, 2);
        tick();
        compared++;
        if (done1 !== 1'b1 || c1 !== 8'hA5) begin
            mismatched++;
            $display("FAIL b2b_first: got done=%b C=%h expected done=1 C=a5", done1, c1);
        end
        drive(1, 1'b1, 32'h3C, 1, 0);
        tick();
        compared++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || c1 !== 8'hA5) begin
            mismatched++;
            $display("FAIL b2b_gap: got busy=%b done=%b C=%h expected busy=0 done=0 C=a5",
                     busy1, done1, c1);
        end
        tick();
        drive(1, 1'b0, 32'h3C, 1, 0);
        compared++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", busy1, done1);
        end
        tick();
        compared++;
        if (done1 !== 1'b1 || c1 !== 8'h78) begin
            mismatched++;
            $display("FAIL b2b_second: got done=%b C=%h expected done=1 C=78", done1, c1);
        end
        tick();
        compared++;
        if (busy1 !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_idle: got busy=%b expected 0", busy1);
        end
    endtask

    task automatic test_reset_mid_op();
        int          lat;
        logic [31:0] res;
        drive(1, 1'b1, 32'h01, 7, 0);
        tick();
        drive(1, 1'b0, 32'h01, 7, 0);
        for (int cyc = 1; cyc <= 3; cyc++) begin
            compared++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                mismatched++;
                $display("FAIL abort_pre cycle %0d: got busy=%b done=%b expected busy=1 done=0",
                         cyc, busy1, done1);
            end
            if (cyc < 3) tick();
        end
        rst = 1'b1;
        drive(1, 1'b1, 32'hFF, 3, 3);
        tick();
        rst = 1'b0;
        drive(1, 1'b0, 32'hFF, 3, 3);
        compared++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || c1 !== 8'h00) begin
            mismatched++;
            $display("FAIL abort_state: got busy=%b done=%b C=%h expected busy=0 done=0 C=00",
                     busy1, done1, c1);
        end
        run_op(1, 32'h81, 1, 2, lat, res);
        compared++;
        if (lat !== 2 || res !== 32'hC0) begin
            mismatched++;
            $display("FAIL abort_restart: got lat=%0d C=%h expected lat=2 C=c0", lat, res);
        end
    endtask

    task automatic test_barrel();
        int          lat;
        logic [31:0] res;
        run_op(3, 32'h0000_0001, 31, 0, lat, res);
        compared++;
        if (lat !== 2 || res !== 32'h8000_0000) begin
            mismatched++;
            $display("FAIL barrel_sll31: got lat=%0d C=%h expected lat=2 C=80000000", lat, res);
        end
    endtask

    task automatic test_random_sweep();
        int          widths [3] = '{8, 8, 32};
        int          steps  [3] = '{1, 2, 32};
        int          lat;
        int          exp_lat;
        int          sh;
        int          md;
        logic [31:0] a;
        logic [31:0] res;
        logic [31:0] exp_c;
        logic [31:0] mask;
        for (int w = 1; w <= 3; w++) begin
            mask = (widths[w-1] == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
            for (int n = 0; n < 33; n++) begin
                a = $urandom() & mask;
                if (n < 8) begin
                    md = n % 4;
                    sh = (n < 4) ? widths[w-1] - 1 : 0;
                end else begin
                    md = int'($urandom_range(3, 0));
                    sh = int'($urandom_range(widths[w-1] - 1, 0));
                end
                exp_c   = ref_shift(widths[w-1], a, sh, md);
                exp_lat = 1 + (sh + steps[w-1] - 1) / steps[w-1];
                run_op(w, a, sh, md, lat, res);
                compared++;
                if (res !== exp_c) begin
                    mismatched++;
                    $display("FAIL sweep_result inst %0d A=%h sh=%0d mode=%0d: got %h expected %h",
                             w, a, sh, md, res, exp_c);
                end
                compared++;
                if (lat !== exp_lat) begin
                    mismatched++;
                    $display("FAIL sweep_latency inst %0d sh=%0d: got %0d expected %0d",
                             w, sh, lat, exp_lat);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        st1 = 1'b0; st2 = 1'b0; st3 = 1'b0;
        a1 = '0; a2 = '0; a3 = '0;
        sh1 = '0; sh2 = '0; sh3 = '0;
        md1 = '0; md2 = '0; md3 = '0;
        test_reset();
        test_sll_busy_window();
        test_sra_srl();
        test_rol_step2();
        test_back_to_back();
        test_reset_mid_op();
        test_barrel();
        test_random_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
Parametrised multi-cycle shift unit, the sequential successor to the catalog's combinational 4-bit sll.
- Shifts an operand by a variable amount in one of four modes (SLL, SRL, SRA, ROL).
- Moves up to STEP bit positions per clock, trading latency for area.
- Uses a start/busy/done handshake, so an ALU or test-harness controller can issue operations and collect results.

Parameters:
WIDTH, 32, operand/result width in bits; power of two, >= 2.
STEP, 1, maximum bit positions shifted per clock; 1 <= STEP <= WIDTH.
SW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
clk    input   1       single clock; all state updates on rising edge
rst    input   1       synchronous, active-high reset
start  input   1       request; accepted only when busy=0
A      input   WIDTH   operand, sampled on accepted start
SHAMT  input   SW      shift amount, sampled on accepted start
MODE   input   2       00 SLL, 01 SRL, 10 SRA, 11 ROL; sampled on accepted start
busy   output  1       high whenever state != IDLE
done   output  1       single-cycle pulse, result valid on C
C      output  WIDTH   result register

Behaviour:
Clocking and reset:
- One clock (clk). Reset is synchronous and active-high (rst).
- rst=1 at an edge: state=IDLE, C=0, busy=0, done=0, internal count=0.

State machine (states IDLE, SHIFT, DONE):
- IDLE: start=1 → C<=A, cnt<=SHAMT, mode latched.
  - Next state is SHIFT if SHAMT!=0, otherwise DONE.
  - start=0 → stay IDLE; C holds its last value.
- SHIFT: each cycle k = min(cnt, STEP), C <= shift(C, k, mode), cnt <= cnt-k.
  - If cnt-k == 0, next state is DONE; otherwise stay in SHIFT.
- DONE: done=1 for exactly this cycle, C holds the final result; next state is IDLE.
  - busy is still 1 in DONE, so back-to-back start is accepted one cycle after done.

Mode arithmetic:
- SLL: zero-fill from the LSB end.
- SRL: zero-fill from the MSB end.
- SRA: fill with the latched operand's sign bit, C[WIDTH-1] at load. The sign is preserved through every step.
- ROL: bits leaving the MSB re-enter at the LSB; no bits are lost.

Latency:
- Start accepted at edge of cycle 0 → done=1 in cycle 1 + ceil(SHAMT/STEP).
- SHAMT=0 → done in cycle 1, C=A.

Boundary conditions:
- start while busy=1 (SHIFT or DONE): ignored; A/SHAMT/MODE changes have no effect on the operation in flight.
- SHAMT max (WIDTH-1):
  - SLL/SRL leave only one surviving bit position.
  - SRA yields all sign bits except the LSB (the original MSB).
  - ROL equals a rotate-right by 1.
- STEP=WIDTH: every op completes in at most 2 cycles after start (SHIFT, DONE); behaves as a registered barrel shifter.
- rst asserted mid-operation: abort at that edge, no done pulse, C=0, IDLE next cycle.
- rst and start in the same cycle: rst wins, start discarded.
- MODE 11 is defined (ROL); no illegal encodings exist.

Decomposition:
Package shift_pkg:
- enum shift_mode_t {SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_ROL=2'b11}.
- enum shift_state_t {ST_IDLE, ST_SHIFT, ST_DONE}.
Sub-module shift_step:
- Combinational, parametrised by WIDTH and STEP.
- Inputs: value, k (0..STEP), mode, sign. Output: shifted value.
- Instantiated once inside shift_unit_seq.
- Unit-testable on its own against the existing combinational sll.

Test Plan:
1. WIDTH=8, STEP=1, A=8'b0000_0011, SHAMT=3, MODE=SLL, one-cycle start → busy high cycles 1-4, done only in cycle 4, C=8'b0001_1000; start pulsed in cycle 2 is ignored.
2. WIDTH=8, STEP=1, A=8'b1000_0000, SHAMT=2, MODE=SRA → done in cycle 3, C=8'b1110_0000. Same operand with MODE=SRL → C=8'b0010_0000.
3. WIDTH=8, STEP=2, A=8'b1001_0110, SHAMT=5, MODE=ROL → done in cycle 4 (steps 2,2,1), C=8'b1101_0010.
4. WIDTH=8, STEP=1, SHAMT=0, A=8'hA5, any MODE → done in cycle 1, C=8'hA5. Back-to-back start held high → second op accepted the cycle after done.
5. WIDTH=8, STEP=1, SHAMT=7, MODE=SLL, rst=1 asserted in cycle 3 → no done pulse, C=0, busy=0 in cycle 4. A new start in cycle 4 completes normally.
6. WIDTH=32, STEP=32 → SHAMT=31 with A=32'h0000_0001, MODE=SLL gives done in cycle 2, C=32'h8000_0000. Randomised sweep over all modes and SHAMT values matches a reference model.
